cam_ctrl: RTL and testbench

Command sequencer in front of the shift-register CAM (`cam_srl`). It accepts lookup, insert and delete-by-key commands over a valid/ready interface and serializes them onto the CAM's compare and write ports. It keeps a valid bitmap so inserts land in the lowest free entry and duplicate keys are never written, and it returns one response per command. It sits between packet-classification logic and the CAM instance, sharing that instance's clock and reset.

---
 rtl/cam_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_cam_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_ctrl.sv
// cam_ctrl: command sequencer in front of the shift-register CAM.
// Serializes lookup / insert / delete-by-key commands onto the CAM compare
// and write ports, keeps a valid bitmap so inserts take the lowest free
// entry and duplicate keys are never written, and returns one response
// per command.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (cmd_ready is combinational)
//   cmd_op, cmd_key              00 lookup, 01 insert, 10 delete, 11 = lookup
//   rsp_valid/rsp_ready          response handshake
//   rsp_status, rsp_addr         00 hit/done, 01 miss, 10 full, 11 present
//   cam_write_*                  CAM write port (busy is an input)
//   cam_compare_data, cam_match* CAM search port
//   used_count, full             occupancy
//
// Optional feature macro: CAM_CTRL_STATS_EN adds stat_hits / stat_misses
// (saturating lookup hit/miss counters).
module cam_ctrl #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [DATA_WIDTH-1:0] cmd_key,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [1:0]            rsp_status,
   output logic [ADDR_WIDTH-1:0] rsp_addr,
   output logic [ADDR_WIDTH-1:0] cam_write_addr,
   output logic [DATA_WIDTH-1:0] cam_write_data,
   output logic                  cam_write_delete,
   output logic                  cam_write_enable,
   input  logic                  cam_write_busy,
   output logic [DATA_WIDTH-1:0] cam_compare_data,
   input  logic                  cam_match,
   input  logic [ADDR_WIDTH-1:0] cam_match_addr,
   output logic [ADDR_WIDTH:0]   used_count,
`ifdef CAM_CTRL_STATS_EN
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses,
`endif
   output logic                  full
);

   localparam int unsigned ENTRIES = 1 << ADDR_WIDTH;
   localparam int unsigned CW      = ADDR_WIDTH + 1;

   localparam logic [1:0] OP_INSERT = 2'b01;
   localparam logic [1:0] OP_DELETE = 2'b10;
   localparam logic [1:0] ST_DONE   = 2'b00;
   localparam logic [1:0] ST_MISS   = 2'b01;
   localparam logic [1:0] ST_FULL   = 2'b10;
   localparam logic [1:0] ST_DUP    = 2'b11;

   typedef enum logic [2:0] {
      IDLE, CMP, EVAL, WRITE, WAIT_HI, WAIT_LO, RESP
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] key_q, key_d;
   logic [ENTRIES-1:0]    bitmap_q, bitmap_d;
   logic [CW-1:0]         used_q, used_d;
   logic                  full_q, full_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [1:0]            status_q, status_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wdel_q, wdel_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
   logic [ADDR_WIDTH-1:0] free_addr_c;
`ifdef CAM_CTRL_STATS_EN
   logic [31:0]           hits_q, hits_d, misses_q, misses_d;
`endif

   // Lowest clear bit of the valid bitmap; scanning downward lets the lowest win.
   always_comb begin
      free_addr_c = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if (!bitmap_q[i]) free_addr_c = ADDR_WIDTH'(i);
      end
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      key_d       = key_q;
      bitmap_d    = bitmap_q;
      used_d      = used_q;
      full_d      = full_q;
      rsp_valid_d = rsp_valid_q;
      status_d    = status_q;
      raddr_d     = raddr_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      wdel_d      = 1'b0;
      we_d        = 1'b0;
      cmp_d       = cmp_q;
      cmd_ready   = 1'b0;
`ifdef CAM_CTRL_STATS_EN
      hits_d      = hits_q;
      misses_d    = misses_q;
`endif
      unique case (state_q)
         IDLE: begin
            // Busy also covers the CAM's post-reset initialisation.
            cmd_ready = !cam_write_busy;
            if (cmd_valid && !cam_write_busy) begin
               op_d    = cmd_op;
               key_d   = cmd_key;
               cmp_d   = cmd_key;
               state_d = CMP;
            end
         end
         CMP: state_d = EVAL;
         EVAL: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            if (op_q == OP_INSERT) begin
               if (cam_match) begin
                  status_d = ST_DUP;
                  raddr_d  = cam_match_addr;
               end else if (full_q) begin
                  status_d = ST_FULL;
                  raddr_d  = '0;
               end else begin
                  rsp_valid_d = 1'b0;
                  waddr_d     = free_addr_c;
                  wdata_d     = key_q;
                  we_d        = 1'b1;
                  state_d     = WRITE;
               end
            end else if (op_q == OP_DELETE) begin
               if (cam_match) begin
                  rsp_valid_d = 1'b0;
                  waddr_d     = cam_match_addr;
                  wdata_d     = key_q;
                  wdel_d      = 1'b1;
                  we_d        = 1'b1;
                  state_d     = WRITE;
               end else begin
                  status_d = ST_MISS;
                  raddr_d  = '0;
               end
            end else begin
               status_d = cam_match ? ST_DONE : ST_MISS;
               raddr_d  = cam_match ? cam_match_addr : '0;
`ifdef CAM_CTRL_STATS_EN
               if (cam_match && hits_q != '1)    hits_d   = hits_q + 32'd1;
               if (!cam_match && misses_q != '1) misses_d = misses_q + 32'd1;
`endif
            end
         end
         WRITE: begin
            if (op_q == OP_DELETE) begin
               bitmap_d[waddr_q] = 1'b0;
               used_d            = used_q - CW'(1);
            end else begin
               bitmap_d[waddr_q] = 1'b1;
               used_d            = used_q + CW'(1);
            end
            full_d   = (used_d == CW'(ENTRIES));
            status_d = ST_DONE;
            raddr_d  = waddr_q;
            state_d  = WAIT_HI;
         end
         WAIT_HI: state_d = WAIT_LO;
         WAIT_LO: begin
            if (!cam_write_busy) begin
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         key_q       <= '0;
         bitmap_q    <= '0;
         used_q      <= '0;
         full_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         status_q    <= '0;
         raddr_q     <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         wdel_q      <= 1'b0;
         we_q        <= 1'b0;
         cmp_q       <= '0;
`ifdef CAM_CTRL_STATS_EN
         hits_q      <= '0;
         misses_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         key_q       <= key_d;
         bitmap_q    <= bitmap_d;
         used_q      <= used_d;
         full_q      <= full_d;
         rsp_valid_q <= rsp_valid_d;
         status_q    <= status_d;
         raddr_q     <= raddr_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         wdel_q      <= wdel_d;
         we_q        <= we_d;
         cmp_q       <= cmp_d;
`ifdef CAM_CTRL_STATS_EN
         hits_q      <= hits_d;
         misses_q    <= misses_d;
`endif
      end
   end

   assign rsp_valid        = rsp_valid_q;
   assign rsp_status       = status_q;
   assign rsp_addr         = raddr_q;
   assign cam_write_addr   = waddr_q;
   assign cam_write_data   = wdata_q;
   assign cam_write_delete = wdel_q;
   assign cam_write_enable = we_q;
   assign cam_compare_data = cmp_q;
   assign used_count       = used_q;
   assign full             = full_q;
`ifdef CAM_CTRL_STATS_EN
   assign stat_hits        = hits_q;
   assign stat_misses      = misses_q;
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl with a behavioural CAM (16-cycle init
// busy after reset, 17-cycle busy after each write, registered match).
module tb_cam_ctrl;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int N  = 32;

   typedef struct packed {
      logic [1:0]    st;
      logic [AW-1:0] addr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [DW-1:0] cmd_key = '0;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [1:0]    rsp_status;
   logic [AW-1:0] rsp_addr;
   logic [AW-1:0] cam_write_addr;
   logic [DW-1:0] cam_write_data;
   logic          cam_write_delete, cam_write_enable;
   logic          cam_busy;
   logic [DW-1:0] cam_compare_data;
   logic          cam_match;
   logic [AW-1:0] cam_match_addr;
   logic [AW:0]   used_count;
   logic          full;
`ifdef CAM_CTRL_STATS_EN
   logic [31:0]   stat_hits, stat_misses;
`endif

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   exp_t exp_q[$];
   logic [DW-1:0] mkey[N];
   logic          mvalid[N];
   int            exp_hits = 0, exp_misses = 0;

   always #5 clk = ~clk;

   cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_addr(rsp_addr),
      .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
      .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
      .cam_write_busy(cam_busy), .cam_compare_data(cam_compare_data),
      .cam_match(cam_match), .cam_match_addr(cam_match_addr),
      .used_count(used_count),
`ifdef CAM_CTRL_STATS_EN
      .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
      .full(full)
   );

   // Behavioural CAM.
   logic [DW-1:0] ck[N];
   logic          cv[N];
   int            busy_cnt;
   always @(posedge clk) begin
      logic          m;
      logic [AW-1:0] ma;
      if (rst) begin
         for (int i = 0; i < N; i++) cv[i] <= 1'b0;
         busy_cnt  <= 16;
         cam_busy  <= 1'b1;
         cam_match <= 1'b0;
         cam_match_addr <= '0;
      end else begin
         m = 1'b0; ma = '0;
         for (int i = N - 1; i >= 0; i--)
            if (cv[i] && ck[i] == cam_compare_data) begin m = 1'b1; ma = AW'(i); end
         cam_match      <= m;
         cam_match_addr <= ma;
         if (cam_write_enable) begin
            if (cam_write_delete) cv[cam_write_addr] <= 1'b0;
            else begin ck[cam_write_addr] <= cam_write_data; cv[cam_write_addr] <= 1'b1; end
            busy_cnt <= 17;
            cam_busy <= 1'b1;
         end else if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
         else begin busy_cnt <= 0; cam_busy <= 1'b0; end
      end
   end

   // Write-enable monitor: never while busy.
   always @(posedge clk) begin
      if (!rst && cam_write_enable) begin
         we_cnt = we_cnt + 1;
         checks = checks + 1;
         if (cam_busy) begin
            errors = errors + 1;
            $display("FAIL we_while_busy busy=%b required=0", cam_busy);
         end
      end
   end

   // Reference model: returns expected response and updates model state.
   task automatic model_cmd(input logic [1:0] op, input logic [DW-1:0] key, output exp_t e);
      int hit = -1, fr = -1;
      for (int i = N - 1; i >= 0; i--) begin
         if (mvalid[i] && mkey[i] == key) hit = i;
         if (!mvalid[i]) fr = i;
      end
      if (op == 2'b01) begin
         if (hit >= 0) e = '{2'b11, AW'(hit)};
         else if (fr < 0) e = '{2'b10, '0};
         else begin mvalid[fr] = 1'b1; mkey[fr] = key; e = '{2'b00, AW'(fr)}; end
      end else if (op == 2'b10) begin
         if (hit >= 0) begin mvalid[hit] = 1'b0; e = '{2'b00, AW'(hit)}; end
         else e = '{2'b01, '0};
      end else begin
         if (hit >= 0) begin e = '{2'b00, AW'(hit)}; exp_hits++; end
         else begin e = '{2'b01, '0}; exp_misses++; end
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (mvalid[i]) c++;
      return c;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < N; i++) mvalid[i] = 1'b0;
   endtask

   // Issue one command, check latency, response, handshake. Called at a negedge.
   task automatic do_cmd(input string nm, input logic [1:0] op, input logic [DW-1:0] key,
                         input int exp_lat, input int hold);
      exp_t e, got;
      int n, cyc;
      model_cmd(op, key, e);
      exp_q.push_back(e);
      cmd_op = op; cmd_key = key; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
      checks++;
      if (!cmd_ready) begin
         errors++; $display("FAIL %s accept ready=%b required=1", nm, cmd_ready);
         cmd_valid = 1'b0; void'(exp_q.pop_front()); return;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 1;
      while (!rsp_valid && cyc < 100) begin @(negedge clk); cyc++; end
      checks++;
      if (!rsp_valid) begin
         errors++; $display("FAIL %s rsp_timeout rsp_valid=%b required=1", nm, rsp_valid);
         void'(exp_q.pop_front()); return;
      end
      if (exp_lat > 0) begin
         checks++;
         if (cyc !== exp_lat) begin
            errors++; $display("FAIL %s latency got=%0d required=%0d", nm, cyc, exp_lat);
         end
      end
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
         checks++;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL %s stall rsp_valid=%b cmd_ready=%b required=1/0", nm, rsp_valid, cmd_ready);
         end
      end
      got = exp_q.pop_front();
      checks++;
      if (rsp_status !== got.st || rsp_addr !== got.addr) begin
         errors++;
         $display("FAIL %s rsp status=%b addr=%0d required status=%b addr=%0d", nm, rsp_status, rsp_addr, got.st, got.addr);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL %s rsp_drop rsp_valid=%b required=0", nm, rsp_valid);
      end
   endtask

   task automatic check_used(input string nm);
      checks++;
      if (used_count !== (AW+1)'(model_count())) begin
         errors++; $display("FAIL %s used_count=%0d required=%0d", nm, used_count, model_count());
      end
   endtask

   task automatic test_reset();
      int n; logic early;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_clear();
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_key = 64'h5;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_status !== 2'b00 || rsp_addr !== '0 || cam_write_enable !== 1'b0
          || cam_write_delete !== 1'b0 || cam_write_addr !== '0 || cam_write_data !== '0
          || cam_compare_data !== '0 || used_count !== '0 || full !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs rv=%b st=%b ad=%0d we=%b cmp=%h used=%0d full=%b required all 0",
                  rsp_valid, rsp_status, rsp_addr, cam_write_enable, cam_compare_data, used_count, full);
      end
      n = 0; early = 1'b0;
      while (!cmd_ready && n < 100) begin
         if (cam_busy && cmd_ready) early = 1'b1;
         @(negedge clk); n++;
      end
      cmd_valid = 1'b0;
      checks++;
      if (!cmd_ready || early || n < 10) begin
         errors++; $display("FAIL reset_ready_gate ready=%b early=%b wait=%0d required ready=1 after init", cmd_ready, early, n);
      end
      @(negedge clk);
   endtask

   task automatic test_insert_lookup();
      do_cmd("ins_A", 2'b01, 64'hA, 22, 0);
      do_cmd("ins_B", 2'b01, 64'hB, 22, 0);
      do_cmd("ins_C", 2'b01, 64'hC, 22, 0);
      do_cmd("lkp_B", 2'b00, 64'hB, 3, 0);
      check_used("used_after_3");
   endtask

   task automatic test_reinsert();
      int w0 = we_cnt;
      do_cmd("reins_A", 2'b01, 64'hA, 3, 0);
      checks++;
      if (we_cnt !== w0) begin
         errors++; $display("FAIL reins_no_write pulses=%0d required=%0d", we_cnt, w0);
      end
      check_used("used_after_reins");
   endtask

   task automatic test_delete();
      do_cmd("del_B", 2'b10, 64'hB, 22, 0);
      do_cmd("lkp_B_miss", 2'b00, 64'hB, 3, 0);
      do_cmd("del_miss", 2'b10, 64'hB, 3, 0);
      do_cmd("lkp_C_op3", 2'b11, 64'hC, 3, 0);
      do_cmd("ins_D", 2'b01, 64'hD, 22, 0);
      check_used("used_after_del");
   endtask

   task automatic test_rsp_stall();
      do_cmd("stall_lkp_D", 2'b00, 64'hD, 3, 5);
      do_cmd("b2b_lkp_A", 2'b00, 64'hA, 3, 0);
   endtask

   task automatic test_full();
      int i = 0;
      while (model_count() < N && i < 64) begin
         do_cmd("fill", 2'b01, 64'h100 + 64'(i), 0, 0);
         i++;
      end
      check_used("used_full");
      checks++;
      if (full !== 1'b1) begin errors++; $display("FAIL full_flag full=%b required=1", full); end
      do_cmd("ins_when_full", 2'b01, 64'hFFFF, 3, 0);
      do_cmd("del_A", 2'b10, 64'hA, 22, 0);
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL full_clear full=%b required=0", full); end
      check_used("used_after_full_del");
   endtask

   task automatic test_rst_midop();
      int n; logic seen;
      cmd_op = 2'b01; cmd_key = 64'h77; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      n = 0;
      while (!cam_write_enable && n < 10) begin @(negedge clk); n++; end
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      seen = 1'b0;
      repeat (30) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      checks++;
      if (seen) begin errors++; $display("FAIL rst_drop rsp_valid_seen=%b required=0", seen); end
      check_used("used_after_rst");
      do_cmd("lkp_after_rst", 2'b00, 64'h77, 3, 0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin mvalid[i] = 1'b0; mkey[i] = '0; end
      @(negedge clk);
      test_reset();
      test_insert_lookup();
      test_reinsert();
      test_delete();
      test_rsp_stall();
      test_full();
      test_rst_midop();
`ifdef CAM_CTRL_STATS_EN
      // Counters were cleared by the mid-op reset; only the last lookup counts.
      checks++;
      if (stat_hits !== 32'd0 || stat_misses !== 32'd1) begin
         errors++; $display("FAIL stats hits=%0d misses=%0d required=0/1", stat_hits, stat_misses);
      end
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_leftover size=%0d required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
